video_timing_gen_v2: RTL and testbench

Parametrised successor to the fixed-width raster timing generator. It produces hsync, vsync and data-enable for the pixel pipeline, plus active-area x/y coordinates and frame/line markers. New over the previous generation:
- register widths are set by parameters;
- configuration is shadowed and applied only at frame boundaries, through a valid/ready handshake with range checking;
- an optional genlock mode re-aligns the raster to an external vsync.

---
 rtl/video_timing_gen_v2_pkg.sv | 25 ++
 rtl/video_timing_gen_v2_if.sv | 29 ++
 rtl/vtg_axis_counter.sv | 55 +++++
 rtl/video_timing_gen_v2.sv | 209 ++++++++++++++++++++
 tb/tb_video_timing_gen_v2.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_gen_v2_pkg.sv
// Shared types and config validation for the raster timing generator.
// Axis records are held at VTG_MAX_W bits; narrower axes zero-extend into them.
package video_timing_gen_v2_pkg;

  localparam int unsigned VTG_MAX_W = 16;

  typedef struct packed {
    logic [VTG_MAX_W-1:0] total;
    logic [VTG_MAX_W-1:0] size;
    logic [VTG_MAX_W-1:0] start;
    logic [VTG_MAX_W-1:0] sync;
  } vtg_axis_cfg_t;

  // Window ends are formed one bit wider so start+size can never wrap.
  function automatic logic vtg_cfg_valid(input vtg_axis_cfg_t h, input vtg_axis_cfg_t v);
    logic [VTG_MAX_W:0] h_end;
    logic [VTG_MAX_W:0] v_end;
    h_end = {1'b0, h.start} + {1'b0, h.size};
    v_end = {1'b0, v.start} + {1'b0, v.size};
    return (h.total >= 16'd2) && (v.total >= 16'd1) &&
           (h.sync < h.total) && (v.sync <= v.total) &&
           (h_end <= {1'b0, h.total}) && (v_end <= {1'b0, v.total});
  endfunction

endpackage

// File: rtl/video_timing_gen_v2_if.sv
// Configuration offer channel: valid/ready handshake, timing fields and reject pulse.
interface video_timing_gen_v2_if #(
  parameter int H_W = 12,
  parameter int V_W = 11
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic           cfg_err;
  logic [H_W-1:0] cfg_h_total;
  logic [H_W-1:0] cfg_h_size;
  logic [H_W-1:0] cfg_h_start;
  logic [H_W-1:0] cfg_h_sync;
  logic [V_W-1:0] cfg_v_total;
  logic [V_W-1:0] cfg_v_size;
  logic [V_W-1:0] cfg_v_start;
  logic [V_W-1:0] cfg_v_sync;

  modport master (
    output cfg_valid, cfg_h_total, cfg_h_size, cfg_h_start, cfg_h_sync,
           cfg_v_total, cfg_v_size, cfg_v_start, cfg_v_sync,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_total, cfg_h_size, cfg_h_start, cfg_h_sync,
           cfg_v_total, cfg_v_size, cfg_v_start, cfg_v_sync,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter with wrap and forced restart, plus
// combinational sync and active-window compares against the applied config.
module vtg_axis_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run_i,
  input  logic         step_i,
  input  logic         force_i,
  input  logic [W-1:0] total_i,
  input  logic [W-1:0] size_i,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] sync_i,
  output logic         end_o,
  output logic         zero_o,
  output logic         sync_o,
  output logic         win_o,
  output logic [W-1:0] idx_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   win_end_s;

  assign end_o     = (cnt_q == (total_i - ONE));
  assign zero_o    = (cnt_q == '0);
  assign sync_o    = (cnt_q < sync_i);
  assign win_end_s = {1'b0, start_i} + {1'b0, size_i};
  assign win_o     = (cnt_q >= start_i) && ({1'b0, cnt_q} < win_end_s);
  assign idx_o     = cnt_q - start_i;

  // Next position: parked at 0 while idle or forced, otherwise advance/wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || force_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = end_o ? '0 : (cnt_q + ONE);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_gen_v2.sv
// Raster timing generator: shadowed config handshake, genlock re-alignment and
// registered sync/enable/coordinate outputs driven from two axis counters.
module video_timing_gen_v2
  import video_timing_gen_v2_pkg::*;
#(
  parameter int H_W = 12,
  parameter int V_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  video_timing_gen_v2_if.slave cfg,
  input  logic                 genlock_en,
  input  logic                 ext_vs,
  output logic                 locked,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [H_W-1:0]       act_x,
  output logic [V_W-1:0]       act_y,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 running
);

  typedef struct packed {
    logic [H_W-1:0] total;
    logic [H_W-1:0] size;
    logic [H_W-1:0] start;
    logic [H_W-1:0] sync;
  } h_cfg_t;

  typedef struct packed {
    logic [V_W-1:0] total;
    logic [V_W-1:0] size;
    logic [V_W-1:0] start;
    logic [V_W-1:0] sync;
  } v_cfg_t;

  h_cfg_t h_in_s, h_sh_q, h_sh_d, h_pd_q, h_pd_d;
  v_cfg_t v_in_s, v_sh_q, v_sh_d, v_pd_q, v_pd_d;
  vtg_axis_cfg_t h_chk_s, v_chk_s;

  logic pend_q, pend_d, run_q, run_d, err_q, err_d;
  logic ext_q, locked_q, locked_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic fs_q, fs_d, ls_q, ls_d;
  logic [H_W-1:0] act_x_q, act_x_d, h_idx_s;
  logic [V_W-1:0] act_y_q, act_y_d, v_idx_s;

  logic h_end_s, h_zero_s, h_sync_s, h_win_s;
  logic v_end_s, v_zero_s, v_sync_s, v_win_s;
  logic frame_end_s, gl_edge_s, force_s, xfer_s, cfg_ok_s, de_s;

  assign h_in_s = '{total: cfg.cfg_h_total, size: cfg.cfg_h_size,
                    start: cfg.cfg_h_start, sync: cfg.cfg_h_sync};
  assign v_in_s = '{total: cfg.cfg_v_total, size: cfg.cfg_v_size,
                    start: cfg.cfg_v_start, sync: cfg.cfg_v_sync};

  assign h_chk_s = '{total: VTG_MAX_W'(h_in_s.total), size: VTG_MAX_W'(h_in_s.size),
                     start: VTG_MAX_W'(h_in_s.start), sync: VTG_MAX_W'(h_in_s.sync)};
  assign v_chk_s = '{total: VTG_MAX_W'(v_in_s.total), size: VTG_MAX_W'(v_in_s.size),
                     start: VTG_MAX_W'(v_in_s.start), sync: VTG_MAX_W'(v_in_s.sync)};
  assign cfg_ok_s = vtg_cfg_valid(h_chk_s, v_chk_s);

  // A coincident ext_vs edge and frame end is a lock hit, never a restart.
  assign frame_end_s = run_q & h_end_s & v_end_s;
  assign gl_edge_s   = genlock_en & run_q & ext_vs & ~ext_q;
  assign force_s     = gl_edge_s & ~frame_end_s;
  assign xfer_s      = cfg.cfg_valid & ~pend_q;
  assign de_s        = run_q & h_win_s & v_win_s;

  vtg_axis_counter #(.W(H_W)) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run_q),
    .step_i  (1'b1),
    .force_i (force_s),
    .total_i (h_sh_q.total),
    .size_i  (h_sh_q.size),
    .start_i (h_sh_q.start),
    .sync_i  (h_sh_q.sync),
    .end_o   (h_end_s),
    .zero_o  (h_zero_s),
    .sync_o  (h_sync_s),
    .win_o   (h_win_s),
    .idx_o   (h_idx_s)
  );

  vtg_axis_counter #(.W(V_W)) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run_q),
    .step_i  (h_end_s),
    .force_i (force_s),
    .total_i (v_sh_q.total),
    .size_i  (v_sh_q.size),
    .start_i (v_sh_q.start),
    .sync_i  (v_sh_q.sync),
    .end_o   (v_end_s),
    .zero_o  (v_zero_s),
    .sync_o  (v_sync_s),
    .win_o   (v_win_s),
    .idx_o   (v_idx_s)
  );

  // Handshake, shadow/pending update, genlock status and output decode.
  always_comb begin
    h_sh_d   = h_sh_q;
    v_sh_d   = v_sh_q;
    h_pd_d   = h_pd_q;
    v_pd_d   = v_pd_q;
    pend_d   = pend_q;
    run_d    = run_q;
    err_d    = 1'b0;
    locked_d = locked_q;
    if (pend_q && (frame_end_s || force_s)) begin
      h_sh_d = h_pd_q;
      v_sh_d = v_pd_q;
      pend_d = 1'b0;
    end else if (xfer_s && !cfg_ok_s) begin
      err_d = 1'b1;
    end else if (xfer_s && !run_q) begin
      h_sh_d = h_in_s;
      v_sh_d = v_in_s;
      run_d  = 1'b1;
    end else if (xfer_s) begin
      h_pd_d = h_in_s;
      v_pd_d = v_in_s;
      pend_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end

    if (!genlock_en) begin
      locked_d = 1'b0;
    end else if (gl_edge_s) begin
      locked_d = frame_end_s;
    end else begin
      locked_d = locked_q;
    end

    hsync_d = run_q & h_sync_s;
    vsync_d = run_q & v_sync_s;
    de_d    = de_s;
    act_x_d = de_s ? h_idx_s : '0;
    act_y_d = de_s ? v_idx_s : '0;
    ls_d    = run_q & h_zero_s;
    fs_d    = run_q & h_zero_s & v_zero_s;
  end

  // Control state: config registers, run/pending flags, genlock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sh_q   <= '0;
      v_sh_q   <= '0;
      h_pd_q   <= '0;
      v_pd_q   <= '0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      ext_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      h_sh_q   <= h_sh_d;
      v_sh_q   <= v_sh_d;
      h_pd_q   <= h_pd_d;
      v_pd_q   <= v_pd_d;
      pend_q   <= pend_d;
      run_q    <= run_d;
      err_q    <= err_d;
      ext_q    <= ext_vs;
      locked_q <= locked_d;
    end
  end

  // Output registers: decode of the current counter state, one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      act_x_q <= '0;
      act_y_q <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      act_x_q <= act_x_d;
      act_y_q <= act_y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign cfg.cfg_ready = ~pend_q;
  assign cfg.cfg_err   = err_q;
  assign locked        = locked_q;
  assign running       = run_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign de            = de_q;
  assign act_x         = act_x_q;
  assign act_y         = act_y_q;
  assign frame_start   = fs_q;
  assign line_start    = ls_q;

endmodule

// File: tb/tb_video_timing_gen_v2.sv
// Bench for video_timing_gen_v2: directed scenarios followed by random traffic,
// every cycle compared against a frame-position reference model.
module tb_video_timing_gen_v2;
  localparam int H_W = 12;
  localparam int V_W = 11;

  logic clk = 1'b0;
  logic rst, genlock_en, ext_vs;
  logic locked, hsync, vsync, de, frame_start, line_start, running;
  logic [H_W-1:0] act_x;
  logic [V_W-1:0] act_y;

  video_timing_gen_v2_if #(.H_W(H_W), .V_W(V_W)) cfg_if ();

  video_timing_gen_v2 #(.H_W(H_W), .V_W(V_W)) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .genlock_en(genlock_en), .ext_vs(ext_vs),
    .locked(locked), .hsync(hsync), .vsync(vsync), .de(de), .act_x(act_x),
    .act_y(act_y), .frame_start(frame_start), .line_start(line_start), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // Reference model: config as [h_total,h_size,h_start,h_sync,v_total,v_size,v_start,v_sync]
  // and the raster position as a single cycle offset inside the frame.
  bit m_run, m_pv, m_ext, m_locked;
  int m_n;
  int mc[8];
  int mp[8];
  int oc[8];

  int de_cnt, err_cnt, hs_rise, vs_rise, ax_max;
  bit prev_hs, prev_vs, saw_not_ready;
  int fs_t[$];
  int ls_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit oc_ok();
    return (oc[0] >= 2) && (oc[4] >= 1) && (oc[3] < oc[0]) && (oc[7] <= oc[4]) &&
           (oc[2] + oc[1] <= oc[0]) && (oc[6] + oc[5] <= oc[4]);
  endfunction

  task automatic drive_fields();
    cfg_if.cfg_h_total = H_W'(oc[0]);
    cfg_if.cfg_h_size  = H_W'(oc[1]);
    cfg_if.cfg_h_start = H_W'(oc[2]);
    cfg_if.cfg_h_sync  = H_W'(oc[3]);
    cfg_if.cfg_v_total = V_W'(oc[4]);
    cfg_if.cfg_v_size  = V_W'(oc[5]);
    cfg_if.cfg_v_start = V_W'(oc[6]);
    cfg_if.cfg_v_sync  = V_W'(oc[7]);
  endtask

  task automatic clear_mon();
    de_cnt = 0; err_cnt = 0; hs_rise = 0; vs_rise = 0; ax_max = 0;
    saw_not_ready = 1'b0;
    fs_t.delete();
    ls_t.delete();
  endtask

  task automatic cyc();
    int h, v, f, n_next, e_ax, e_ay;
    bit e_hs, e_vs, e_de, e_fs, e_ls, e_err, fe, gl, xfer, ok, s_rst, s_gen, s_ext;
    logic [31:0] exp_v, obs_v;
    h = 0; v = 0; f = 1; e_ax = 0; e_ay = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_ls = 0; e_err = 0;
    s_rst = rst; s_gen = genlock_en; s_ext = ext_vs;
    if (m_run) begin
      f = mc[0] * mc[4];
      h = m_n % mc[0];
      v = m_n / mc[0];
      e_hs = h < mc[3];
      e_vs = v < mc[7];
      e_de = (h >= mc[2]) && (h < mc[2] + mc[1]) && (v >= mc[6]) && (v < mc[6] + mc[5]);
      if (e_de) begin
        e_ax = h - mc[2];
        e_ay = v - mc[6];
      end
      e_ls = (h == 0);
      e_fs = (m_n == 0);
    end
    fe   = m_run && (m_n == f - 1);
    gl   = s_gen && m_run && s_ext && !m_ext;
    xfer = cfg_if.cfg_valid && !m_pv;
    ok   = oc_ok();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (s_rst) begin
      m_run = 0; m_pv = 0; m_ext = 0; m_locked = 0; m_n = 0;
      for (int i = 0; i < 8; i++) begin mc[i] = 0; mp[i] = 0; end
      e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_ls = 0; e_ax = 0; e_ay = 0;
    end else begin
      n_next = !m_run ? 0 : (gl && !fe) ? 0 : (m_n + 1) % f;
      if (m_pv && (fe || gl)) begin
        mc = mp;
        m_pv = 0;
      end
      e_err = xfer && !ok;
      if (xfer && ok) begin
        if (!m_run) begin
          mc = oc; m_run = 1; n_next = 0;
        end else begin
          mp = oc; m_pv = 1;
        end
      end
      m_n = n_next;
      m_locked = !s_gen ? 1'b0 : (gl ? fe : m_locked);
      m_ext = s_ext;
    end
    exp_v = {m_run, !m_pv, e_err, m_locked, e_hs, e_vs, e_de, e_fs, e_ls,
             H_W'(e_ax), V_W'(e_ay)};
    obs_v = {running, cfg_if.cfg_ready, cfg_if.cfg_err, locked, hsync, vsync, de,
             frame_start, line_start, act_x, act_y};
    chk("raster", obs_v, exp_v);
    de_cnt += int'(de);
    err_cnt += int'(cfg_if.cfg_err);
    if (hsync && !prev_hs) hs_rise++;
    if (vsync && !prev_vs) vs_rise++;
    prev_hs = hsync;
    prev_vs = vsync;
    if (de && int'(act_x) > ax_max) ax_max = int'(act_x);
    if (!cfg_if.cfg_ready) saw_not_ready = 1'b1;
    if (frame_start) fs_t.push_back(cyc_cnt);
    if (line_start) ls_t.push_back(cyc_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic offer(input int ht, hsz, hst, hs, vt, vsz, vst, vs);
    oc[0] = ht; oc[1] = hsz; oc[2] = hst; oc[3] = hs;
    oc[4] = vt; oc[5] = vsz; oc[6] = vst; oc[7] = vs;
    drive_fields();
    cfg_if.cfg_valid = 1'b1;
    cyc();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic run_until(input int target);
    int k;
    k = 0;
    while (!(m_run && m_n == target) && k < 2000) begin
      cyc();
      k++;
    end
    if (k >= 2000) begin
      errors++;
      $error("FAIL run_until observed=timeout expected=position %0d", target);
    end
  endtask

  initial begin
    int c0, bad, d;
    rst = 1'b1; genlock_en = 1'b0; ext_vs = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) oc[i] = 0;
    drive_fields();
    m_run = 0; m_pv = 0; m_ext = 0; m_locked = 0; m_n = 0;
    prev_hs = 0; prev_vs = 0;
    clear_mon();

    // Reset state
    cyc();
    chk("rst_ready", cfg_if.cfg_ready, 32'd1);
    chk("rst_running", running, 32'd0);
    rst = 1'b0;
    run(2);

    // Basic raster
    clear_mon();
    c0 = cyc_cnt;
    offer(10, 4, 3, 2, 5, 2, 1, 1);
    run(50);
    chk("basic_de_count", de_cnt, 32'd8);
    chk("basic_act_x_max", ax_max, 32'd3);
    run(60);
    chk("basic_fs_count", fs_t.size(), 32'd3);
    if (fs_t.size() >= 2) begin
      chk("basic_first_fs_lat", fs_t[0] - c0, 32'd2);
      chk("basic_frame_period", fs_t[1] - fs_t[0], 32'd50);
    end

    // Invalid configs, including a start+size that only fits with wrap
    clear_mon();
    offer(10, 4, 8, 2, 5, 2, 1, 1);
    run(3);
    chk("inv_err_cnt", err_cnt, 32'd1);
    offer(10, 2, 4095, 2, 5, 2, 1, 1);
    run(3);
    chk("inv_wrap_err_cnt", err_cnt, 32'd2);
    chk("inv_ready_low_seen", saw_not_ready, 32'd0);

    // Mid-frame reconfiguration to a 12-clock line
    run_until(2 * 10 + 3);
    clear_mon();
    offer(12, 4, 3, 2, 5, 2, 1, 1);
    chk("mid_ready_low", cfg_if.cfg_ready, 32'd0);
    run(130);
    chk("mid_fs_cnt", fs_t.size() >= 2, 32'd1);
    if (fs_t.size() >= 2) chk("mid_fs_period", fs_t[1] - fs_t[0], 32'd60);
    bad = 0;
    for (int i = 1; i < ls_t.size(); i++) begin
      d = ls_t[i] - ls_t[i-1];
      if (d != 10 && d != 12) bad++;
    end
    chk("mid_line_len", bad, 32'd0);
    if (ls_t.size() >= 2) chk("mid_new_line", ls_t[ls_t.size()-1] - ls_t[ls_t.size()-2], 32'd12);

    // Genlock: misaligned edge forces restart, aligned edges lock
    genlock_en = 1'b1;
    run_until(1 * 12 + 4);
    ext_vs = 1'b1;
    cyc();
    ext_vs = 1'b0;
    chk("gl_locked0", locked, 32'd0);
    cyc();
    chk("gl_restart_fs", frame_start, 32'd1);
    for (int k = 0; k < 3; k++) begin
      run_until(59);
      ext_vs = 1'b1;
      cyc();
      ext_vs = 1'b0;
    end
    chk("gl_locked1", locked, 32'd1);
    run(5);

    // Reset mid-line with a pending config outstanding
    run_until(5);
    offer(10, 4, 3, 2, 5, 2, 1, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_running", running, 32'd0);
    chk("rst_mid_ready", cfg_if.cfg_ready, 32'd1);
    chk("rst_mid_locked", locked, 32'd0);
    chk("rst_mid_outs", {hsync, vsync, de, frame_start, line_start, act_x, act_y}, 32'd0);

    // Zero vertical size
    genlock_en = 1'b0;
    run(2);
    offer(10, 4, 3, 2, 5, 0, 1, 1);
    clear_mon();
    run(150);
    chk("zero_de", de_cnt, 32'd0);
    chk("zero_hs_rise", hs_rise, 32'd15);
    chk("zero_vs_rise", vs_rise, 32'd3);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 63) == 0) genlock_en = ~genlock_en;
      ext_vs = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) begin
        oc[0] = int'($urandom_range(1, 12));
        oc[1] = int'($urandom_range(0, 6));
        oc[2] = int'($urandom_range(0, 12));
        oc[3] = int'($urandom_range(0, 12));
        oc[4] = int'($urandom_range(0, 6));
        oc[5] = int'($urandom_range(0, 3));
        oc[6] = int'($urandom_range(0, 6));
        oc[7] = int'($urandom_range(0, 6));
        drive_fields();
        cfg_if.cfg_valid = 1'b1;
      end else begin
        cfg_if.cfg_valid = 1'b0;
      end
      cyc();
    end
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    ext_vs = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
